// File: rtl/ysyx_24090018_pkg.sv
// Shared decode constants, ALU operation enum and the ALU evaluation helper
// for the ysyx_24090018 RV32I integer datapath.
package ysyx_24090018_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int REG_ADDR   = 5;
    localparam int REG_NUM    = 2 ** REG_ADDR;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        SLL  = 4'd2,
        SLT  = 4'd3,
        SLTU = 4'd4,
        XOR  = 4'd5,
        SRL  = 4'd6,
        SRA  = 4'd7,
        OR   = 4'd8,
        AND  = 4'd9
    } alu_op_e;

    // Shift amount always comes from the low five bits of operand 2.
    function automatic logic [DATA_WIDTH-1:0] alu_exec(
        input alu_op_e               op,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            ADD:     alu_exec = a + b;
            SUB:     alu_exec = a - b;
            SLL:     alu_exec = a << sh;
            SLT:     alu_exec = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            SLTU:    alu_exec = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
            XOR:     alu_exec = a ^ b;
            SRL:     alu_exec = a >> sh;
            SRA:     alu_exec = DATA_WIDTH'($signed(a) >>> sh);
            OR:      alu_exec = a | b;
            AND:     alu_exec = a & b;
            default: alu_exec = {DATA_WIDTH{1'b0}};
        endcase
    endfunction

endpackage

// File: rtl/ysyx_24090018_idu_exu_rf_if.sv
// Fetch-side bus of the decode/execute/register-file block: instruction in,
// ALU operands and write-back data out.
interface ysyx_24090018_idu_exu_rf_if;
    import ysyx_24090018_pkg::*;

    logic [DATA_WIDTH-1:0] inst_i;
    logic [DATA_WIDTH-1:0] op1_o;
    logic [DATA_WIDTH-1:0] op2_o;
    logic [DATA_WIDTH-1:0] rf_wdata_o;

    modport master (
        output inst_i,
        input  op1_o,
        input  op2_o,
        input  rf_wdata_o
    );

    modport slave (
        input  inst_i,
        output op1_o,
        output op2_o,
        output rf_wdata_o
    );

endinterface

// File: rtl/ysyx_24090018_idu_exu_rf_regfile.sv
// 32-entry integer register file: two asynchronous read ports, one
// synchronous write port, synchronous active-high clear; x0 is hard zero.
module ysyx_24090018_RegisterFile
    import ysyx_24090018_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [REG_ADDR-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [REG_ADDR-1:0]   rs1,
    input  logic [REG_ADDR-1:0]   rs2,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2
);

    logic [DATA_WIDTH-1:0] regs_q [REG_NUM];

    // Register storage: clear on reset, otherwise single write, x0 never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (wen && (waddr != {REG_ADDR{1'b0}})) begin
            regs_q[waddr] <= wdata;
        end
    end

    // No bypass: a read in the same cycle as a write sees the old contents.
    assign rdata1 = (rs1 == {REG_ADDR{1'b0}}) ? {DATA_WIDTH{1'b0}} : regs_q[rs1];
    assign rdata2 = (rs2 == {REG_ADDR{1'b0}}) ? {DATA_WIDTH{1'b0}} : regs_q[rs2];

endmodule

// File: rtl/ysyx_24090018_idu_exu_rf.sv
// Single-cycle RV32I decode + ALU + register file (OP-IMM, OP, LUI).
// Define YSYX_24090018_OPTRACE_EN to print a per-cycle operand/result trace.
module ysyx_24090018_idu_exu_rf
    import ysyx_24090018_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    ysyx_24090018_idu_exu_rf_if.slave  bus
);

    logic [6:0]            opcode_s;
    logic [REG_ADDR-1:0]   rd_s;
    logic [2:0]            funct3_s;
    logic [REG_ADDR-1:0]   rs1_s;
    logic [REG_ADDR-1:0]   rs2_s;
    logic [6:0]            funct7_s;
    logic [DATA_WIDTH-1:0] imm_i_s;
    logic [DATA_WIDTH-1:0] imm_u_s;
    logic [DATA_WIDTH-1:0] rdata1_s;
    logic [DATA_WIDTH-1:0] rdata2_s;
    logic [DATA_WIDTH-1:0] op1_s;
    logic [DATA_WIDTH-1:0] op2_s;
    logic [DATA_WIDTH-1:0] result_s;
    logic                  legal_s;
    logic                  wen_s;
    alu_op_e               alu_op_s;

    assign opcode_s = bus.inst_i[6:0];
    assign rd_s     = bus.inst_i[11:7];
    assign funct3_s = bus.inst_i[14:12];
    assign rs1_s    = bus.inst_i[19:15];
    assign rs2_s    = bus.inst_i[24:20];
    assign funct7_s = bus.inst_i[31:25];
    assign imm_i_s  = {{20{bus.inst_i[31]}}, bus.inst_i[31:20]};
    assign imm_u_s  = {bus.inst_i[31:12], 12'h000};

    // Decode: select operands and ALU op; illegal encodings leave everything at zero.
    always_comb begin
        legal_s  = 1'b0;
        op1_s    = {DATA_WIDTH{1'b0}};
        op2_s    = {DATA_WIDTH{1'b0}};
        alu_op_s = ADD;
        case (opcode_s)
            OP_IMM: begin
                legal_s = 1'b1;
                op1_s   = rdata1_s;
                op2_s   = imm_i_s;
                case (funct3_s)
                    F3_ADD_SUB: alu_op_s = ADD;
                    F3_SLL:     alu_op_s = SLL;
                    F3_SLT:     alu_op_s = SLT;
                    F3_SLTU:    alu_op_s = SLTU;
                    F3_XOR:     alu_op_s = XOR;
                    F3_SRL_SRA: alu_op_s = bus.inst_i[30] ? SRA : SRL;
                    F3_OR:      alu_op_s = OR;
                    F3_AND:     alu_op_s = AND;
                    default:    alu_op_s = ADD;
                endcase
            end
            OP: begin
                if ((funct7_s == F7_BASE) || (funct7_s == F7_ALT)) begin
                    legal_s = 1'b1;
                    op1_s   = rdata1_s;
                    op2_s   = rdata2_s;
                    case (funct3_s)
                        F3_ADD_SUB: alu_op_s = funct7_s[5] ? SUB : ADD;
                        F3_SLL:     alu_op_s = SLL;
                        F3_SLT:     alu_op_s = SLT;
                        F3_SLTU:    alu_op_s = SLTU;
                        F3_XOR:     alu_op_s = XOR;
                        F3_SRL_SRA: alu_op_s = funct7_s[5] ? SRA : SRL;
                        F3_OR:      alu_op_s = OR;
                        F3_AND:     alu_op_s = AND;
                        default:    alu_op_s = ADD;
                    endcase
                end else begin
                    legal_s = 1'b0;
                end
            end
            LUI: begin
                legal_s  = 1'b1;
                op1_s    = {DATA_WIDTH{1'b0}};
                op2_s    = imm_u_s;
                alu_op_s = ADD;
            end
            default: begin
                legal_s = 1'b0;
            end
        endcase
    end

    assign result_s = legal_s ? alu_exec(alu_op_s, op1_s, op2_s) : {DATA_WIDTH{1'b0}};
    assign wen_s    = legal_s && (rd_s != {REG_ADDR{1'b0}}) && !rst;

    assign bus.op1_o      = op1_s;
    assign bus.op2_o      = op2_s;
    assign bus.rf_wdata_o = result_s;

    ysyx_24090018_RegisterFile u_rf (
        .clk    (clk),
        .rst    (rst),
        .wen    (wen_s),
        .waddr  (rd_s),
        .wdata  (result_s),
        .rs1    (rs1_s),
        .rs2    (rs2_s),
        .rdata1 (rdata1_s),
        .rdata2 (rdata2_s)
    );

`ifdef YSYX_24090018_OPTRACE_EN
    // Simulation-only trace of each retired cycle.
    always @(posedge clk) begin
        if (!rst) begin
            if (wen_s) begin
                $display("[OPTRACE] op1=%0d op2=%0d rf_wdata=%0d rd=%0d",
                         op1_s, op2_s, result_s, rd_s);
            end else begin
                $display("[OPTRACE] op1=%0d op2=%0d rf_wdata=%0d",
                         op1_s, op2_s, result_s);
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_ysyx_24090018_idu_exu_rf.sv
// Self-checking bench for ysyx_24090018_idu_exu_rf: an instruction-level
// reference model checked every cycle, plus hand-computed directed checks.
module tb_ysyx_24090018_idu_exu_rf;

    logic clk;
    logic rst;
    bit   check_en;
    int   n_tests;
    int   n_fail;

    logic [31:0] m_rf [32];

    ysyx_24090018_idu_exu_rf_if bus ();

    ysyx_24090018_idu_exu_rf dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (inst 0x%08h, t=%0t)",
                     name, act, exp, bus.inst_i, $time);
        end
    endtask

    function automatic logic [31:0] rd_reg(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'd0 : m_rf[idx];
    endfunction

    // Architectural meaning of one instruction against the model register file.
    task automatic model_exec(input logic [31:0] in, output bit legal,
                              output logic [31:0] a, output logic [31:0] b,
                              output logic [31:0] r);
        logic [6:0] opc;
        logic [6:0] f7;
        logic [2:0] f3;
        int         sh;
        opc = in[6:0];
        f7  = in[31:25];
        f3  = in[14:12];
        legal = 1'b0;
        a = 32'd0;
        b = 32'd0;
        r = 32'd0;
        if (opc == 7'h13) begin
            legal = 1'b1;
            a = rd_reg(in[19:15]);
            b = {{20{in[31]}}, in[31:20]};
        end else if (opc == 7'h33 && (f7 == 7'h00 || f7 == 7'h20)) begin
            legal = 1'b1;
            a = rd_reg(in[19:15]);
            b = rd_reg(in[24:20]);
        end else if (opc == 7'h37) begin
            legal = 1'b1;
            b = {in[31:12], 12'h000};
            r = b;
        end
        sh = int'(b % 32'd32);
        if (legal && opc != 7'h37) begin
            if (f3 == 3'd0)      r = (opc == 7'h33 && f7 == 7'h20) ? a - b : a + b;
            else if (f3 == 3'd1) r = a << sh;
            else if (f3 == 3'd2) r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            else if (f3 == 3'd3) r = (a < b) ? 32'd1 : 32'd0;
            else if (f3 == 3'd4) r = a ^ b;
            else if (f3 == 3'd5) r = in[30] ? 32'(int'(a) >>> sh) : a >> sh;
            else if (f3 == 3'd6) r = a | b;
            else                 r = a & b;
        end
    endtask

    // Model state advances on the same edge as the DUT.
    always @(posedge clk) begin
        bit          legal;
        logic [31:0] a, b, r;
        if (rst) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        end else begin
            model_exec(bus.inst_i, legal, a, b, r);
            if (legal && bus.inst_i[11:7] != 5'd0) m_rf[bus.inst_i[11:7]] = r;
        end
    end

    // Every cycle, compare combinational outputs against the model.
    always @(negedge clk) begin
        bit          legal;
        logic [31:0] a, b, r;
        if (check_en) begin
            model_exec(bus.inst_i, legal, a, b, r);
            check("model_op1", bus.op1_o, a);
            check("model_op2", bus.op2_o, b);
            check("model_wdata", bus.rf_wdata_o, r);
        end
    end

    task automatic apply(input logic [31:0] in, input logic r);
        @(posedge clk);
        #1;
        bus.inst_i = in;
        rst = r;
        @(negedge clk);
        #1;
    endtask

    task automatic rand_inst(output logic [31:0] in);
        logic [31:0] w;
        logic [2:0]  f3;
        int          kind;
        w    = $urandom;
        f3   = w[14:12];
        kind = $urandom_range(0, 2);
        if (kind == 0) begin
            in = {w[31:7], 7'h13};
            if (f3 == 3'd1) in[31:25] = 7'h00;
            if (f3 == 3'd5) in[31:25] = {1'b0, w[30], 5'b00000};
        end else if (kind == 1) begin
            in = {7'h00, w[24:7], 7'h33};
            if (f3 == 3'd0 || f3 == 3'd5) in[30] = w[30];
        end else begin
            in = {w[31:7], 7'h37};
        end
    endtask

    initial begin
        logic [31:0] ri;
        n_tests = 0;
        n_fail  = 0;
        check_en = 1'b0;
        rst = 1'b1;
        bus.inst_i = 32'h0000_0000;
        repeat (2) @(posedge clk);
        #1;
        check_en = 1'b1;

        // Reset state: operands of add x3,x1,x2 read zero.
        apply(32'h002081B3, 1'b1);
        check("rst_op1", bus.op1_o, 32'h0);
        check("rst_op2", bus.op2_o, 32'h0);

        apply(32'h00500093, 1'b0);
        check("addi_op1", bus.op1_o, 32'd0);
        check("addi_op2", bus.op2_o, 32'd5);
        check("addi_wd", bus.rf_wdata_o, 32'd5);
        apply(32'hFFD08113, 1'b0);
        check("addi_neg_op1", bus.op1_o, 32'd5);
        check("addi_neg_op2", bus.op2_o, 32'hFFFFFFFD);
        check("addi_neg_wd", bus.rf_wdata_o, 32'd2);
        apply(32'h402081B3, 1'b0);
        check("sub_wd", bus.rf_wdata_o, 32'd3);
        apply(32'h0001A233, 1'b0);
        check("slt_wd", bus.rf_wdata_o, 32'd0);
        apply(32'hFFF00293, 1'b0);
        check("x5_m1", bus.rf_wdata_o, 32'hFFFFFFFF);
        apply(32'h00503333, 1'b0);
        check("sltu_wd", bus.rf_wdata_o, 32'd1);
        apply(32'h123453B7, 1'b0);
        check("lui_op1", bus.op1_o, 32'd0);
        check("lui_op2", bus.op2_o, 32'h12345000);
        check("lui_wd", bus.rf_wdata_o, 32'h12345000);
        apply(32'h4043D413, 1'b0);
        check("srai_wd", bus.rf_wdata_o, 32'h01234500);
        apply(32'h4012D4B3, 1'b0);
        check("sra_wd", bus.rf_wdata_o, 32'hFFFFFFFF);

        // x0 writes are dropped.
        apply(32'h00700013, 1'b0);
        check("x0_wd", bus.rf_wdata_o, 32'd7);
        apply(32'h00100513, 1'b0);
        check("x0_read", bus.op1_o, 32'd0);
        check("x0_read_wd", bus.rf_wdata_o, 32'd1);

        // Illegal encodings produce zeros and do not write.
        apply(32'h00000000, 1'b0);
        check("ill0_op1", bus.op1_o, 32'd0);
        check("ill0_wd", bus.rf_wdata_o, 32'd0);
        apply(32'h022085B3, 1'b0);
        check("mul_op1", bus.op1_o, 32'd0);
        check("mul_op2", bus.op2_o, 32'd0);
        check("mul_wd", bus.rf_wdata_o, 32'd0);
        apply(32'h022080B3, 1'b0);
        apply(32'h00058633, 1'b0);
        check("x11_unchanged", bus.op1_o, 32'd0);
        apply(32'h00008693, 1'b0);
        check("x1_unchanged", bus.op1_o, 32'd5);

        // Model-checked sweep of assorted legal encodings.
        for (int i = 0; i < 60; i++) begin
            rand_inst(ri);
            apply(ri, 1'b0);
        end

        // Mid-stream reset overrides the pending write.
        apply(32'h00900093, 1'b0);
        apply(32'h00108093, 1'b1);
        check("rst_cycle_op1", bus.op1_o, 32'd9);
        check("rst_cycle_wd", bus.rf_wdata_o, 32'd10);
        apply(32'h00008713, 1'b0);
        check("post_rst_x1", bus.op1_o, 32'd0);
        apply(32'h002287B3, 1'b0);
        check("post_rst_op1", bus.op1_o, 32'd0);
        check("post_rst_op2", bus.op2_o, 32'd0);

        @(posedge clk);
        #1;
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
